fir_coeff_loader: RTL and testbench



---
 rtl/fir_coeff_loader.sv | 144 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Shadow coefficient bank for the symmetric bit-serial FIR, plus FIR start-strobe arbitration.
// Optional macro FIR_COEFF_LOADER_AUTO_COMMIT_EN: a write to the last index also commits next cycle.
module fir_coeff_loader #(
    parameter int DataWidth = 12,
    parameter int NTaps     = 8,
    localparam int NCoeffs   = NTaps / 2,
    localparam int AddrWidth = (NCoeffs > 1) ? $clog2(NCoeffs) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic                 commit,
    output logic                 busy,
    input  logic                 start_in,
    output logic                 start_out,
    output logic                 start_dropped,
    input  logic                 fir_done,
    output logic                 coeff_load_out,
    output logic                 coeff_out
);

    localparam int NBits    = NCoeffs * DataWidth;
    localparam int CntWidth = (NBits > 1) ? $clog2(NBits) : 1;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NCoeffs - 1);
    localparam logic [CntWidth-1:0]  LastBit  = CntWidth'(NBits - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT, ST_GAP} state_t;

    state_t               state_q, state_d;
    logic [DataWidth-1:0] shadow_q [NCoeffs];
    logic [NBits-1:0]     shadow_flat;
    logic [CntWidth-1:0]  bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic                 fir_active_q, fir_active_d;
    logic                 coeff_load_q, coeff_load_d;
    logic                 coeff_q, coeff_d;
    logic                 start_dropped_q, start_dropped_d;
    logic                 addr_ok, wr_accept, commit_eff;

    // Out-of-range indices only exist when NCoeffs is not a power of two.
    generate
        if ((1 << AddrWidth) > NCoeffs) begin : g_addr_chk
            assign addr_ok = (wr_addr <= LastAddr);
        end else begin : g_addr_full
            assign addr_ok = 1'b1;
        end
    endgenerate

    assign wr_accept = wr_en && (state_q == ST_IDLE) && addr_ok;

`ifdef FIR_COEFF_LOADER_AUTO_COMMIT_EN
    logic auto_commit_q, auto_commit_d;

    assign auto_commit_d = wr_accept && (wr_addr == LastAddr);
    assign commit_eff    = commit | auto_commit_q;

    always_ff @(posedge clk) begin
        if (rst) auto_commit_q <= 1'b0;
        else     auto_commit_q <= auto_commit_d;
    end
`else
    assign commit_eff = commit;
`endif

    // Bit k*DataWidth+b of the flat view is shadow[k][b]; serial bit j is its bit NBits-1-j.
    always_comb begin
        shadow_flat = '0;
        for (int k = 0; k < NCoeffs; k++) begin
            shadow_flat[k*DataWidth +: DataWidth] = shadow_q[k];
        end
    end

    assign bit_cnt_inc = bit_cnt_q + 1'b1;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        coeff_load_d = 1'b0;
        coeff_d      = 1'b0;
        start_out    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                start_out = start_in & ~commit_eff;
                if (commit_eff) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!fir_active_q) begin
                    state_d      = ST_SHIFT;
                    bit_cnt_d    = '0;
                    coeff_load_d = 1'b1;
                    coeff_d      = shadow_flat[NBits-1];
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == LastBit) begin
                    state_d = ST_GAP;
                end else begin
                    bit_cnt_d    = bit_cnt_inc;
                    coeff_load_d = 1'b1;
                    coeff_d      = shadow_flat[LastBit - bit_cnt_inc];
                end
            end
            ST_GAP: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A start in the same cycle as fir_done re-arms the flag (set wins).
    assign fir_active_d    = start_out ? 1'b1 : (fir_done ? 1'b0 : fir_active_q);
    assign start_dropped_d = start_in & ~start_out;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            fir_active_q    <= 1'b0;
            coeff_load_q    <= 1'b0;
            coeff_q         <= 1'b0;
            start_dropped_q <= 1'b0;
            // NOTE: the bank is cleared on reset so a post-reset commit never streams stale values.
            for (int k = 0; k < NCoeffs; k++) shadow_q[k] <= '0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            fir_active_q    <= fir_active_d;
            coeff_load_q    <= coeff_load_d;
            coeff_q         <= coeff_d;
            start_dropped_q <= start_dropped_d;
            if (wr_accept) shadow_q[wr_addr] <= wr_data;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign start_dropped  = start_dropped_q;
    assign coeff_load_out = coeff_load_q;
    assign coeff_out      = coeff_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: an event-level model queues expected starts, drops
// and coefficient loads; a negedge monitor compares them against what the DUT presents.
module tb_fir_coeff_loader;

    localparam int DW    = 12;
    localparam int NT    = 8;
    localparam int NC    = NT / 2;
    localparam int AW    = 2;
    localparam int NBITS = NC * DW;

    logic          clk = 1'b0;
    logic          rst, wr_en, commit, start_in, fir_done;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, start_out, start_dropped, coeff_load_out, coeff_out;

    fir_coeff_loader #(.DataWidth(DW), .NTaps(NT)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit        (commit),
        .busy          (busy),
        .start_in      (start_in),
        .start_out     (start_out),
        .start_dropped (start_dropped),
        .fir_done      (fir_done),
        .coeff_load_out(coeff_load_out),
        .coeff_out     (coeff_out)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_edge = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    typedef logic [NC-1:0][DW-1:0] bank_t;
    typedef struct packed {
        int    busy_start;
        int    shift_start;
        int    busy_end;
        logic  aborted;
        bank_t coeffs;
    } load_t;

    int    start_q[$];
    int    drop_q[$];
    load_t load_q[$];

    bank_t m_shadow = '0;
    bank_t m_snapshot = '0;
    bit    m_wait = 1'b0;
    bit    m_fir_active = 1'b0;
    int    m_wait_from = 0;
    int    m_busy_start = 0;
    int    m_busy_end = 0;
    int    m_auto_cycle = -1;

    function automatic bit model_idle(input int c);
        return !m_wait && (c >= m_busy_end);
    endfunction

    task automatic model_step(input int c, input bit we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input bit cm, input bit si,
                              input bit fd, input bit rs);
        bit    idle, ce, exp_start;
        load_t rec;
        if (rs) begin
            if (!m_wait && c < m_busy_end && load_q.size() > 0) begin
                rec          = load_q.pop_back();
                rec.busy_end = c + 1;
                rec.aborted  = 1'b1;
                load_q.push_back(rec);
            end
            m_shadow     = '0;
            m_wait       = 1'b0;
            m_fir_active = 1'b0;
            m_busy_end   = 0;
            m_auto_cycle = -1;
            return;
        end
        idle      = model_idle(c);
        ce        = cm || (c == m_auto_cycle);
        exp_start = si && idle && !ce;
        if (exp_start) start_q.push_back(c);
        if (si && !exp_start) drop_q.push_back(c + 1);
        if (idle && we) begin
            m_shadow[wa] = wd;
`ifdef FIR_COEFF_LOADER_AUTO_COMMIT_EN
            if (wa == AW'(NC - 1)) m_auto_cycle = c + 1;
`endif
        end
        if (idle && ce) begin
            m_wait       = 1'b1;
            m_wait_from  = c + 1;
            m_busy_start = c + 1;
            m_snapshot   = m_shadow;
        end else if (m_wait && c >= m_wait_from && !m_fir_active) begin
            m_wait          = 1'b0;
            m_busy_end      = c + 1 + NBITS + 1;
            rec.busy_start  = m_busy_start;
            rec.shift_start = c + 1;
            rec.busy_end    = m_busy_end;
            rec.aborted     = 1'b0;
            rec.coeffs      = m_snapshot;
            load_q.push_back(rec);
        end
        if (exp_start) m_fir_active = 1'b1;
        else if (fd)   m_fir_active = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit cm, input bit si, input bit fd, input bit rs);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        commit   = cm;
        start_in = si;
        fir_done = fd;
        rst      = rs;
        model_step(cyc, we, wa, wd, cm, si, fd, rs);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(1'b1, a, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (model_idle(cyc)) break;
            idle_cycle();
        end
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Directed load with ignored write, starts in SHIFT/GAP and a second commit in SHIFT.
        write(2'd0, 12'h001);
        write(2'd1, 12'h002);
        write(2'd2, 12'h004);
        write(2'd3, 12'h7FF);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 52; i++)
            drive(i == 7, 2'd0, 12'hABC, i == 17, (i == 12) || (i == 50), 1'b0, 1'b0);
        wait_idle();

        // Start accepted in IDLE, then a commit that must wait for fir_done.
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) idle_cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // Commit and start in the same IDLE cycle: commit wins.
        write(2'd2, 12'h5A5);
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle();

        // Reset at SHIFT cycle 20, then a fresh load.
        write(2'd1, 12'h3C3);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 22; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, i == 22);
        repeat (3) idle_cycle();
        write(2'd0, 12'h800);
        write(2'd3, 12'h123);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Randomised traffic.
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 3) == 0, AW'($urandom_range(0, NC - 1)), DW'($urandom),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, 1'b0);
        wait_idle();

        // Write to the last index: loads only when auto-commit is built in.
        write(2'd3, 12'h0F0);
        repeat (4) idle_cycle();
        wait_idle();
        repeat (4) idle_cycle();

        check("pending_start_out", start_q.size(), 0);
        check("pending_start_dropped", drop_q.size(), 0);
        check("pending_loads", load_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    int          busy_rise = 0;
    int          load_rise = 0;
    logic        busy_prev = 1'b0;
    logic        load_prev = 1'b0;
    logic        rx_bits[$];

    always @(negedge clk) begin
        load_t            rec;
        int               errs;
        int               exp_len;
        logic [NBITS-1:0] sr;

        if (rst_edge) begin
            check("reset_busy", busy, 0);
            check("reset_coeff_load_out", coeff_load_out, 0);
            check("reset_coeff_out", coeff_out, 0);
            check("reset_start_dropped", start_dropped, 0);
        end

        if (start_out === 1'b1) begin
            if (start_q.size() == 0) check("start_out_unexpected", cyc, -1);
            else                     check("start_out_cycle", cyc, start_q.pop_front());
        end
        if (start_dropped === 1'b1) begin
            if (drop_q.size() == 0) check("start_dropped_unexpected", cyc, -1);
            else                    check("start_dropped_cycle", cyc, drop_q.pop_front());
        end

        if (busy === 1'b1 && busy_prev !== 1'b1) begin
            busy_rise = cyc;
            rx_bits.delete();
        end
        if (coeff_load_out === 1'b1 && load_prev !== 1'b1) load_rise = cyc;
        if (coeff_load_out === 1'b1) rx_bits.push_back(coeff_out);
        else if (!rst_edge)          check("coeff_out_idle", coeff_out, 0);

        if (busy !== 1'b1 && busy_prev === 1'b1) begin
            if (load_q.size() == 0) begin
                check("load_unexpected", busy_rise, -1);
            end else begin
                rec = load_q.pop_front();
                check("busy_rise_cycle", busy_rise, rec.busy_start);
                check("shift_start_cycle", load_rise, rec.shift_start);
                check("busy_fall_cycle", cyc, rec.busy_end);
                exp_len = rec.aborted ? (rec.busy_end - rec.shift_start) : NBITS;
                check("shift_length", rx_bits.size(), exp_len);
                errs = 0;
                foreach (rx_bits[j])
                    if (j < NBITS && rx_bits[j] !== rec.coeffs[NC - 1 - j / DW][DW - 1 - j % DW])
                        errs++;
                check("stream_bit_errors", errs, 0);
                if (!rec.aborted) begin
                    // FIR view: each serial bit shifts into one long coefficient chain.
                    sr = '0;
                    foreach (rx_bits[j]) sr = {sr[NBITS-2:0], rx_bits[j]};
                    for (int k = 0; k < NC; k++)
                        check("fir_coeff", sr[k*DW +: DW], rec.coeffs[k]);
                end
            end
        end

        busy_prev = busy;
        load_prev = coeff_load_out;
    end

endmodule
